// File: rtl/life_step_controller_if.sv
// Loader and display-readout handshake bundle for life_step_controller.
// The master side is the pattern loader / display; the slave side is the controller.
interface life_step_controller_if;
  logic        load_valid;
  logic        load_ready;
  logic [1:0]  load_tile;
  logic [15:0] load_data;
  logic        rd_req;
  logic [1:0]  rd_tile;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic [15:0] rd_data_prev;

  modport master (
    output load_valid, load_tile, load_data, rd_req, rd_tile,
    input  load_ready, rd_ack, rd_data, rd_data_prev
  );

  modport slave (
    input  load_valid, load_tile, load_data, rd_req, rd_tile,
    output load_ready, rd_ack, rd_data, rd_data_prev
  );
endinterface

// File: rtl/life_step_controller.sv
// Step sequencer and write-port arbiter for the 8x8 life tile array, plus tile readout.
// Optional macro LIFE_CTRL_MISS_CNT_EN adds a saturating missed_steps counter output.
module life_step_controller #(
  parameter int                  PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(24'd4999999),
  parameter int                  GEN_W          = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                single_step,
  input  logic                period_load,
  input  logic [PERIOD_W-1:0] period_val,
  life_step_controller_if.slave bus,
  output logic [15:0]         vali,
  output logic [1:0]          vali_selector,
  output logic                write_enb,
  output logic                step,
  output logic [1:0]          valo_selector,
  input  logic [15:0]         valo,
  input  logic [15:0]         valo_prev,
  output logic [GEN_W-1:0]    gen_count,
  output logic                busy
`ifdef LIFE_CTRL_MISS_CNT_EN
  ,
  output logic [7:0]          missed_steps
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, STEP, SETTLE} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic                stepPending_q, stepPending_d;
  logic                grant_q;
  logic [15:0]         vali_q;
  logic [1:0]          valiSel_q;
  logic                writeEnb_q;
  logic                step_q;
  logic [1:0]          valoSel_q;
  logic                rdPending_q;
  logic                rdAck_q;
  logic [15:0]         rdData_q;
  logic [15:0]         rdPrev_q;
  logic [GEN_W-1:0]    gen_q;
  logic [7:0]          missed_q;

  logic expiry;
  logic stepReq;
  logic goStep;
  logic loadReady;
  logic accept;
  logic captureRd;

  always_comb begin
    expiry        = run && !period_load && (timer_q == period_q);
    stepReq       = expiry || (single_step && !run);
    goStep        = (state_q == IDLE) && stepPending_q && (!grant_q || !bus.load_valid);
    // Gated by reset so the loader never sees a grant while the block is held in reset.
    loadReady     = reset && (state_q == IDLE) && !goStep;
    accept        = loadReady && bus.load_valid;
    captureRd     = rdPending_q && !bus.rd_req && ((state_q == IDLE) || (state_q == WRITE));
    timer_d       = (!run || period_load || expiry) ? '0 : timer_q + 1'b1;
    stepPending_d = (state_q == STEP) ? 1'b0 : (stepPending_q || stepReq);
    state_d       = state_q;
    case (state_q)
      IDLE:    if (goStep) state_d = STEP;
               else if (accept) state_d = WRITE;
      WRITE:   state_d = IDLE;
      STEP:    state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      period_q      <= DEFAULT_PERIOD;
      timer_q       <= '0;
      stepPending_q <= 1'b0;
      grant_q       <= 1'b0;
      vali_q        <= '0;
      valiSel_q     <= '0;
      writeEnb_q    <= 1'b0;
      step_q        <= 1'b0;
      valoSel_q     <= '0;
      rdPending_q   <= 1'b0;
      rdAck_q       <= 1'b0;
      rdData_q      <= '0;
      rdPrev_q      <= '0;
      gen_q         <= '0;
      missed_q      <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stepPending_q <= stepPending_d;
      writeEnb_q    <= accept;
      step_q        <= goStep;
      rdAck_q       <= captureRd;
      if (period_load) period_q <= period_val;
      if (accept) begin
        vali_q    <= bus.load_data;
        valiSel_q <= bus.load_tile;
      end
      // Grant favours the loader in the first IDLE after each step.
      if (accept) grant_q <= 1'b0;
      else if (state_q == STEP) grant_q <= 1'b1;
      if (state_q == STEP) gen_q <= gen_q + 1'b1;
      if (bus.rd_req) valoSel_q <= bus.rd_tile;
      rdPending_q <= bus.rd_req || (rdPending_q && !captureRd);
      if (captureRd) begin
        rdData_q <= valo;
        rdPrev_q <= valo_prev;
      end
      if (stepReq && stepPending_q && (missed_q != 8'hFF)) missed_q <= missed_q + 8'd1;
    end
  end

  assign bus.load_ready   = loadReady;
  assign bus.rd_ack       = rdAck_q;
  assign bus.rd_data      = rdData_q;
  assign bus.rd_data_prev = rdPrev_q;
  assign vali             = vali_q;
  assign vali_selector    = valiSel_q;
  assign write_enb        = writeEnb_q;
  assign step             = step_q;
  assign valo_selector    = valoSel_q;
  assign gen_count        = gen_q;
  assign busy             = (state_q != IDLE);

`ifdef LIFE_CTRL_MISS_CNT_EN
  assign missed_steps = missed_q;
`else
  logic unusedMissed;
  assign unusedMissed = ^missed_q;
`endif

endmodule

// File: tb/tb_life_step_controller.sv
// Scoreboard bench for life_step_controller: drivers queue expectations, a negedge monitor
// pops and compares them whenever the DUT strobes write_enb, step or rd_ack.
module tb_life_step_controller;
  localparam int PW = 24;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          run, single_step, period_load;
  logic [PW-1:0] period_val;
  logic [15:0]   vali, valo, valo_prev;
  logic [1:0]    vali_selector, valo_selector;
  logic          write_enb, step, busy;
  logic [GW-1:0] gen_count;
`ifdef LIFE_CTRL_MISS_CNT_EN
  logic [7:0]    missed_steps;
`endif

  life_step_controller_if bus();

  life_step_controller #(.PERIOD_W(PW), .DEFAULT_PERIOD(24'd4999999), .GEN_W(GW)) dut (
    .clk(clk), .reset(reset), .run(run), .single_step(single_step),
    .period_load(period_load), .period_val(period_val), .bus(bus.slave),
    .vali(vali), .vali_selector(vali_selector), .write_enb(write_enb), .step(step),
    .valo_selector(valo_selector), .valo(valo), .valo_prev(valo_prev),
    .gen_count(gen_count), .busy(busy)
`ifdef LIFE_CTRL_MISS_CNT_EN
    , .missed_steps(missed_steps)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Behavioural tile array: writes replace a tile, a step shifts current into previous.
  logic [15:0] tileCur[4];
  logic [15:0] tilePrev[4];
  assign valo      = tileCur[valo_selector];
  assign valo_prev = tilePrev[valo_selector];
  always @(posedge clk) begin
    if (!reset || step) begin
      for (int i = 0; i < 4; i++) begin
        tilePrev[i] <= reset ? tileCur[i] : 16'($urandom);
        tileCur[i]  <= 16'($urandom);
      end
    end else if (write_enb) begin
      tileCur[vali_selector] <= vali;
    end
  end

  logic [17:0] writeQ[$];
  logic [31:0] readQ[$];
  int          genQ[$];
  int          genExp = 0;
  bit          genCheck = 1'b1;
  bit          gapCheck = 1'b0;
  int          expGap = 0;
  int          lastStep = -1;
  int          stepSeen = 0;
  int          lastWriteCycle = 0;
  bit          genChkPend = 1'b0;
  int          expGenVal = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout/unexpected event, want expected event", name);
  endtask

  // Monitor: every strobe from the DUT consumes one queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (genChkPend) begin
        checkOutput("gen_count_after_step", 32'(gen_count), 32'(expGenVal));
        genChkPend = 1'b0;
      end
      if (write_enb) begin
        lastWriteCycle = cycleCnt;
        checkOutput("write_step_exclusive", 32'(step), 32'd0);
        checkOutput("busy_in_write", 32'(busy), 32'd1);
        if (writeQ.size() == 0) flagFail("unexpected_write");
        else checkOutput("write_tile_data", 32'({vali_selector, vali}), 32'(writeQ.pop_front()));
      end
      if (step) begin
        stepSeen++;
        if (gapCheck) begin
          if (lastStep >= 0) checkOutput("step_gap", 32'(cycleCnt - lastStep), 32'(expGap));
          lastStep = cycleCnt;
        end
        if (genCheck) begin
          if (genQ.size() == 0) flagFail("unexpected_step");
          else begin
            expGenVal  = genQ.pop_front();
            genChkPend = 1'b1;
          end
        end
      end
      if (bus.rd_ack) begin
        if (readQ.size() == 0) flagFail("unexpected_rd_ack");
        else checkOutput("rd_data_pair", {bus.rd_data, bus.rd_data_prev}, readQ.pop_front());
      end
    end
  end

  // Present one load and hold it until accepted; waits reports extra cycles spent waiting.
  task automatic applyStimulus(input logic [1:0] tile, input logic [15:0] data, output int waits);
    bit ok = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_tile  = tile;
    bus.load_data  = data;
    waits = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.load_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (ok) writeQ.push_back({tile, data});
    else flagFail("load_accept_timeout");
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
  endtask

  task automatic waitAck();
    bit ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rd_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flagFail("rd_ack_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic applyRead(input logic [1:0] tile);
    bus.rd_req  = 1'b1;
    bus.rd_tile = tile;
    @(posedge clk);
    #1 bus.rd_req = 1'b0;
    readQ.push_back({tileCur[tile], tilePrev[tile]});
    waitAck();
  endtask

  task automatic loadPeriod(input logic [PW-1:0] p);
    period_load = 1'b1;
    period_val  = p;
    @(posedge clk);
    #1 period_load = 1'b0;
  endtask

  task automatic runPeriod(input int p, input int cycles);
    int n = cycles / (p + 1);
    loadPeriod(PW'(p));
    for (int i = 0; i < n; i++) genQ.push_back(++genExp);
    expGap   = p + 1;
    lastStep = -1;
    gapCheck = 1'b1;
    run      = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 run = 1'b0;
    repeat (6) @(posedge clk);
    #1 gapCheck = 1'b0;
    checkOutput("period_steps_all_seen", 32'(genQ.size()), 32'd0);
    checkOutput("period_gen_count", 32'(gen_count), 32'(genExp));
  endtask

  initial begin
    int w, startCycle, seenBefore;
    reset = 1'b0; run = 1'b0; single_step = 1'b0; period_load = 1'b0; period_val = '0;
    bus.load_valid = 1'b0; bus.load_tile = '0; bus.load_data = '0;
    bus.rd_req = 1'b0; bus.rd_tile = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'({write_enb, step, busy, bus.load_ready, bus.rd_ack}), 32'd0);
    checkOutput("reset_gen_count", 32'(gen_count), 32'd0);
    checkOutput("reset_rd_data", {bus.rd_data, bus.rd_data_prev}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed load and random load/read traffic");
    applyStimulus(2'd2, 16'hA5C3, w);
    checkOutput("load_ready_in_idle", 32'(w), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) applyStimulus(2'($urandom), 16'($urandom), w);
      else applyRead(2'($urandom));
    end

    $display("[TB] single step and readout during STEP");
    genQ.push_back(++genExp);
    single_step = 1'b1;
    @(posedge clk);
    #1 single_step = 1'b0;
    @(posedge clk);
    #1 checkOutput("single_step_pulse", 32'(step), 32'd1);
    bus.rd_req  = 1'b1;
    bus.rd_tile = 2'd3;
    @(posedge clk);
    #1 bus.rd_req = 1'b0;
    readQ.push_back({tileCur[3], tilePrev[3]});
    checkOutput("valo_selector_latched", 32'(valo_selector), 32'd3);
    checkOutput("rd_ack_held_in_settle", 32'({busy, bus.rd_ack}), 32'b10);
    waitAck();

    $display("[TB] single step ignored while running");
    loadPeriod(PW'(1000));
    seenBefore = stepSeen;
    run = 1'b1;
    single_step = 1'b1;
    @(posedge clk);
    #1 single_step = 1'b0;
    repeat (12) @(posedge clk);
    #1 run = 1'b0;
    checkOutput("no_step_when_running", 32'(stepSeen - seenBefore), 32'd0);

    $display("[TB] period timer");
    runPeriod(9, 100);
    runPeriod($urandom_range(2, 12), $urandom_range(30, 90));

`ifdef LIFE_CTRL_MISS_CNT_EN
    $display("[TB] missed step counter");
    genQ.push_back(++genExp);
    single_step = 1'b1;
    repeat (3) @(posedge clk);
    #1 single_step = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkOutput("missed_steps", 32'(missed_steps), 32'd2);
`endif

    $display("[TB] fairness at period 0");
    checkOutput("queues_empty_before_fairness", 32'(genQ.size() + readQ.size() + writeQ.size()), 32'd0);
    loadPeriod('0);
    genCheck   = 1'b0;
    startCycle = cycleCnt;
    run        = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(2'(i), 16'($urandom), w);
    run = 1'b0;
    checkOutput("fair_four_writes_le16", 32'(lastWriteCycle - startCycle <= 16), 32'd1);
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] reset during WRITE");
    bus.load_valid = 1'b1;
    bus.load_tile  = 2'd1;
    bus.load_data  = 16'h1234;
    writeQ.push_back({2'd1, 16'h1234});
    @(negedge clk);
    @(negedge clk);
    checkOutput("write_before_reset", 32'(write_enb), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_strobes_drop", 32'({write_enb, step, busy}), 32'd0);
    checkOutput("reset_gen_cleared", 32'(gen_count), 32'd0);
    @(negedge clk);
    checkOutput("load_ready_low_in_reset", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    genExp   = 0;
    genCheck = 1'b1;
    seenBefore = stepSeen;
    run = 1'b1;
    repeat (30) @(posedge clk);
    #1 run = 1'b0;
    checkOutput("default_period_restored", 32'(stepSeen - seenBefore), 32'd0);
    checkOutput("queues_empty_at_end", 32'(genQ.size() + readQ.size() + writeQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish, want finish");
    $fatal(1, "[TB] timeout");
  end
endmodule
